xbus_acc_bridge: RTL and testbench

XBUS slave that terminates the NEORV32 external bus and bridges it to the neuromorphic accelerator stream interface. It decodes a small register window at `BASE_ADDR`. CPU writes are pushed into a TX FIFO that streams words to the accelerator. Accelerator results land in an RX FIFO that the CPU pops by reads. A status register and an optional RX interrupt let firmware poll or wait.

---
 rtl/xbus_acc_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/xbus_acc_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_xbus_acc_bridge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/xbus_acc_pkg.sv
// Shared constants and types for the XBUS-to-accelerator bridge: register map,
// STATUS/CTRL bit positions and the bus-response FSM state type.
package xbus_acc_pkg;

    localparam logic [7:0] OFF_TXDATA = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;
    localparam logic [7:0] OFF_CTRL   = 8'h0C;

    localparam int STAT_TX_EMPTY   = 0;
    localparam int STAT_TX_FULL    = 1;
    localparam int STAT_RX_EMPTY   = 2;
    localparam int STAT_RX_FULL    = 3;
    localparam int STAT_TX_LVL_LSB = 8;
    localparam int STAT_RX_LVL_LSB = 16;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_FLUSH  = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } bus_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; pushes into a full FIFO
// and pops from an empty one are dropped, flush wins over both.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (level_r == LW'(DEPTH));
    assign empty     = (level_r == LW'(0));
    assign level     = level_r;
    assign head      = mem_r[rd_ptr_r];
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Pointer and level bookkeeping; pointers wrap modulo DEPTH by width.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_r + LW'(do_push_s) - LW'(do_pop_s);
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/xbus_acc_bridge.sv
// XBUS slave bridging CPU register accesses to the accelerator TX/RX streams.
// Optional RX interrupt enabled by defining XBUS_ACC_BRIDGE_IRQ_EN.
module xbus_acc_bridge
    import xbus_acc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
    parameter int          WIN_BITS   = 8,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] xbus_adr_i,
    input  logic [31:0] xbus_dat_i,
    input  logic [2:0]  xbus_tag_i,
    input  logic        xbus_we_i,
    input  logic [3:0]  xbus_sel_i,
    input  logic        xbus_stb_i,
    input  logic        xbus_cyc_i,
    output logic [31:0] xbus_dat_o,
    output logic        xbus_ack_o,
    output logic        xbus_err_o,
    output logic [31:0] acc_tx_data_o,
    output logic        acc_tx_valid_o,
    input  logic        acc_tx_ready_i,
    input  logic [31:0] acc_rx_data_i,
    input  logic        acc_rx_valid_i,
    output logic        acc_rx_ready_o,
    output logic        irq_o
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WIN_BITS-1:0] A_TXDATA = WIN_BITS'(OFF_TXDATA);
    localparam logic [WIN_BITS-1:0] A_RXDATA = WIN_BITS'(OFF_RXDATA);
    localparam logic [WIN_BITS-1:0] A_STATUS = WIN_BITS'(OFF_STATUS);
    localparam logic [WIN_BITS-1:0] A_CTRL   = WIN_BITS'(OFF_CTRL);

    bus_state_e        state_r, state_nxt_s;
    logic              ack_r, err_r, init_done_r;
    logic [31:0]       rdata_r;
    logic              resp_ack_s, resp_err_s;
    logic [31:0]       rdata_s, status_s;
    logic              hit_s, tx_push_s, rx_pop_s, ctrl_wr_s, flush_s, irq_en_s;
    logic [WIN_BITS-1:0] offset_s;
    logic              tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [LW-1:0]     tx_level_s, rx_level_s;
    logic [31:0]       tx_head_s, rx_head_s;
    logic              unused_tag_s;

    assign unused_tag_s = ^xbus_tag_i;
    assign offset_s     = xbus_adr_i[WIN_BITS-1:0];
    assign hit_s        = xbus_stb_i & xbus_cyc_i &
                          (xbus_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign flush_s      = ctrl_wr_s & xbus_sel_i[0] & xbus_dat_i[CTRL_FLUSH];

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush   (flush_s),
        .push    (tx_push_s),
        .pop     (acc_tx_valid_o & acc_tx_ready_i),
        .wr_data (xbus_dat_i),
        .full    (tx_full_s),
        .empty   (tx_empty_s),
        .level   (tx_level_s),
        .head    (tx_head_s)
    );

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush   (flush_s),
        .push    (acc_rx_valid_i & acc_rx_ready_o),
        .pop     (rx_pop_s),
        .wr_data (acc_rx_data_i),
        .full    (rx_full_s),
        .empty   (rx_empty_s),
        .level   (rx_level_s),
        .head    (rx_head_s)
    );

    assign acc_tx_valid_o = ~tx_empty_s;
    assign acc_tx_data_o  = tx_empty_s ? 32'h0 : tx_head_s;
    // Held low through reset; rises one cycle after reset is released.
    assign acc_rx_ready_o = init_done_r & ~rx_full_s;

`ifdef XBUS_ACC_BRIDGE_IRQ_EN
    logic irq_en_r;

    // RX interrupt enable bit, written through CTRL byte 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_en_r <= 1'b0;
        end else if (ctrl_wr_s && xbus_sel_i[0]) begin
            irq_en_r <= xbus_dat_i[CTRL_IRQ_EN];
        end
    end

    assign irq_en_s = irq_en_r;
    assign irq_o    = irq_en_r & ~rx_empty_s;
`else
    assign irq_en_s = 1'b0;
    assign irq_o    = 1'b0;
`endif

    // STATUS word assembly from the FIFO flags and levels.
    always_comb begin
        status_s                             = 32'h0;
        status_s[STAT_TX_EMPTY]              = tx_empty_s;
        status_s[STAT_TX_FULL]               = tx_full_s;
        status_s[STAT_RX_EMPTY]              = rx_empty_s;
        status_s[STAT_RX_FULL]               = rx_full_s;
        status_s[STAT_TX_LVL_LSB +: 8]       = 8'(tx_level_s);
        status_s[STAT_RX_LVL_LSB +: 8]       = 8'(rx_level_s);
    end

    // Bus FSM next state, register decode and side-effect strobes.
    always_comb begin
        state_nxt_s = state_r;
        tx_push_s   = 1'b0;
        rx_pop_s    = 1'b0;
        ctrl_wr_s   = 1'b0;
        resp_ack_s  = 1'b0;
        resp_err_s  = 1'b0;
        rdata_s     = 32'h0;
        case (state_r)
            ST_IDLE: begin
                if (hit_s) begin
                    state_nxt_s = ST_RESP;
                    resp_err_s  = 1'b1;
                    case (offset_s)
                        A_TXDATA: begin
                            if (xbus_we_i && !tx_full_s && (xbus_sel_i == 4'b1111)) begin
                                tx_push_s  = 1'b1;
                                resp_ack_s = 1'b1;
                                resp_err_s = 1'b0;
                            end else begin
                                tx_push_s  = 1'b0;
                            end
                        end
                        A_RXDATA: begin
                            if (!xbus_we_i && !rx_empty_s) begin
                                rx_pop_s   = 1'b1;
                                resp_ack_s = 1'b1;
                                resp_err_s = 1'b0;
                                rdata_s    = rx_head_s;
                            end else begin
                                rx_pop_s   = 1'b0;
                            end
                        end
                        A_STATUS: begin
                            if (!xbus_we_i) begin
                                resp_ack_s = 1'b1;
                                resp_err_s = 1'b0;
                                rdata_s    = status_s;
                            end else begin
                                resp_ack_s = 1'b0;
                            end
                        end
                        A_CTRL: begin
                            resp_ack_s = 1'b1;
                            resp_err_s = 1'b0;
                            if (xbus_we_i) begin
                                ctrl_wr_s = 1'b1;
                            end else begin
                                rdata_s[CTRL_IRQ_EN] = irq_en_s;
                            end
                        end
                        default: resp_err_s = 1'b1;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state and registered response; response lives only in the RESP cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            rdata_r     <= 32'h0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            ack_r       <= resp_ack_s;
            err_r       <= resp_err_s;
            rdata_r     <= rdata_s;
            init_done_r <= 1'b1;
        end
    end

    // A master that drops cyc before the response cycle gets no handshake.
    assign xbus_ack_o = ack_r & xbus_cyc_i;
    assign xbus_err_o = err_r & xbus_cyc_i;
    assign xbus_dat_o = (ack_r & xbus_cyc_i) ? rdata_r : 32'h0;

endmodule

// File: tb/tb_xbus_acc_bridge.sv
// Directed self-checking bench for xbus_acc_bridge (default depth 16, 256 B window).
module tb_xbus_acc_bridge;

    localparam logic [31:0] BASE = 32'hF000_0000;
`ifdef XBUS_ACC_BRIDGE_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif
    localparam logic [31:0] R_ACK  = 32'h1;
    localparam logic [31:0] R_ERR  = 32'h2;
    localparam logic [31:0] R_NONE = 32'h0;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] xbus_adr_i = 32'h0, xbus_dat_i = 32'h0;
    logic [2:0]  xbus_tag_i = 3'h0;
    logic        xbus_we_i = 1'b0, xbus_stb_i = 1'b0, xbus_cyc_i = 1'b0;
    logic [3:0]  xbus_sel_i = 4'h0;
    logic [31:0] xbus_dat_o, acc_tx_data_o;
    logic        xbus_ack_o, xbus_err_o, acc_tx_valid_o, acc_rx_ready_o, irq_o;
    logic        acc_tx_ready_i = 1'b0, acc_rx_valid_i = 1'b0;
    logic [31:0] acc_rx_data_i = 32'h0;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic        r_ack, r_err, r_late, r_txv;
    logic [31:0] r_dat, r_txd;

    xbus_acc_bridge dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .xbus_adr_i     (xbus_adr_i),
        .xbus_dat_i     (xbus_dat_i),
        .xbus_tag_i     (xbus_tag_i),
        .xbus_we_i      (xbus_we_i),
        .xbus_sel_i     (xbus_sel_i),
        .xbus_stb_i     (xbus_stb_i),
        .xbus_cyc_i     (xbus_cyc_i),
        .xbus_dat_o     (xbus_dat_o),
        .xbus_ack_o     (xbus_ack_o),
        .xbus_err_o     (xbus_err_o),
        .acc_tx_data_o  (acc_tx_data_o),
        .acc_tx_valid_o (acc_tx_valid_o),
        .acc_tx_ready_i (acc_tx_ready_i),
        .acc_rx_data_i  (acc_rx_data_i),
        .acc_rx_valid_i (acc_rx_valid_i),
        .acc_rx_ready_o (acc_rx_ready_o),
        .irq_o          (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access started at a falling edge; samples the response cycle and the one after.
    task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
        xbus_we_i  = we;
        xbus_adr_i = adr;
        xbus_dat_i = dat;
        xbus_sel_i = sel;
        xbus_stb_i = 1'b1;
        xbus_cyc_i = 1'b1;
        @(negedge clk_i);
        r_ack = xbus_ack_o;
        r_err = xbus_err_o;
        r_dat = xbus_dat_o;
        r_txv = acc_tx_valid_o;
        r_txd = acc_tx_data_o;
        xbus_stb_i     = 1'b0;
        acc_rx_valid_i = 1'b0;
        @(negedge clk_i);
        r_late     = xbus_ack_o | xbus_err_o;
        xbus_cyc_i = 1'b0;
        xbus_we_i  = 1'b0;
    endtask

    task automatic acc(input string tag, input logic we, input logic [31:0] off,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input logic [31:0] exp_resp, input logic [31:0] exp_dat);
        req(we, BASE + off, dat, sel);
        check({tag, "_resp"}, {29'h0, r_late, r_err, r_ack}, exp_resp);
        if (!we) begin
            check({tag, "_data"}, r_dat, exp_dat);
        end
    endtask

    initial begin
        // reset
        @(negedge clk_i);
        @(negedge clk_i);
        check("reset_outs", {27'h0, xbus_ack_o, xbus_err_o, acc_tx_valid_o, acc_rx_ready_o, irq_o}, 32'h0);
        check("reset_dat", xbus_dat_o | acc_tx_data_o, 32'h0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rx_ready_after_reset", {31'h0, acc_rx_ready_o}, 32'h1);

        // first TX word visible in the ack cycle
        acc("tx_write", 1'b1, 32'h0, 32'hDEAD_BEEF, 4'hF, R_ACK, 32'h0);
        check("tx_valid_ack_cycle", {31'h0, r_txv}, 32'h1);
        check("tx_data_ack_cycle", r_txd, 32'hDEAD_BEEF);
        acc("status_1", 1'b0, 32'h8, 32'h0, 4'hF, R_ACK, 32'h0000_0104);

        // fill to 16, 17th errors
        for (int i = 1; i < 16; i++) begin
            acc("tx_fill", 1'b1, 32'h0, 32'h1000_0000 + i, 4'hF, R_ACK, 32'h0);
        end
        acc("tx_overflow", 1'b1, 32'h0, 32'hBAD0_BAD0, 4'hF, R_ERR, 32'h0);
        acc("status_full", 1'b0, 32'h8, 32'h0, 4'hF, R_ACK, 32'h0000_1006);

        // drain in order
        acc_tx_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("tx_drain", acc_tx_data_o, (i == 0) ? 32'hDEAD_BEEF : 32'h1000_0000 + i);
            @(negedge clk_i);
        end
        acc_tx_ready_i = 1'b0;
        check("tx_empty_after_drain", {31'h0, acc_tx_valid_o}, 32'h0);
        acc("status_drained", 1'b0, 32'h8, 32'h0, 4'hF, R_ACK, 32'h0000_0005);
        acc("tx_wrap", 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, R_ACK, 32'h0);
        check("tx_wrap_data", acc_tx_data_o, 32'hA5A5_A5A5);
        acc_tx_ready_i = 1'b1;
        @(negedge clk_i);
        acc_tx_ready_i = 1'b0;
        check("tx_wrap_popped", {31'h0, acc_tx_valid_o}, 32'h0);

        // RX word, interrupt, pop, empty-pop error
        acc_rx_data_i  = 32'h0000_0055;
        acc_rx_valid_i = 1'b1;
        @(negedge clk_i);
        acc_rx_valid_i = 1'b0;
        acc("ctrl_irq_en", 1'b1, 32'hC, 32'h1, 4'hF, R_ACK, 32'h0);
        check("irq_pending", {31'h0, irq_o}, {31'h0, IRQ_ON});
        acc("ctrl_read", 1'b0, 32'hC, 32'h0, 4'hF, R_ACK, {31'h0, IRQ_ON});
        acc("rx_read", 1'b0, 32'h4, 32'h0, 4'hF, R_ACK, 32'h0000_0055);
        check("irq_cleared", {31'h0, irq_o}, 32'h0);
        acc("rx_empty_read", 1'b0, 32'h4, 32'h0, 4'hF, R_ERR, 32'h0);

        // concurrent CPU pop and accelerator push
        acc_rx_valid_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            acc_rx_data_i = 32'h11 * i;
            @(negedge clk_i);
        end
        acc_rx_valid_i = 1'b1;
        acc_rx_data_i  = 32'h44;
        acc("rx_pop_push", 1'b0, 32'h4, 32'h0, 4'hF, R_ACK, 32'h11);
        acc("status_rx3", 1'b0, 32'h8, 32'h0, 4'hF, R_ACK, 32'h0003_0001);
        acc("rx_read2", 1'b0, 32'h4, 32'h0, 4'hF, R_ACK, 32'h22);
        acc("rx_read3", 1'b0, 32'h4, 32'h0, 4'hF, R_ACK, 32'h33);
        acc("rx_read4", 1'b0, 32'h4, 32'h0, 4'hF, R_ACK, 32'h44);
        acc("status_rx0", 1'b0, 32'h8, 32'h0, 4'hF, R_ACK, 32'h0000_0005);

        // decode errors and misses
        acc("bad_offset", 1'b0, 32'h10, 32'h0, 4'hF, R_ERR, 32'h0);
        acc("miss", 1'b1, 32'h100, 32'h1234_5678, 4'hF, R_NONE, 32'h0);
        acc("tx_partial_sel", 1'b1, 32'h0, 32'h1234_5678, 4'h3, R_ERR, 32'h0);
        acc("tx_read", 1'b0, 32'h0, 32'h0, 4'hF, R_ERR, 32'h0);
        acc("status_write", 1'b1, 32'h8, 32'h0, 4'hF, R_ERR, 32'h0);
        acc("rx_write", 1'b1, 32'h4, 32'h0, 4'hF, R_ERR, 32'h0);
        acc("status_no_push", 1'b0, 32'h8, 32'h0, 4'hF, R_ACK, 32'h0000_0005);

        // cyc dropped before response: no handshake, push stands
        xbus_we_i  = 1'b1;
        xbus_adr_i = BASE;
        xbus_dat_i = 32'h77;
        xbus_sel_i = 4'hF;
        xbus_stb_i = 1'b1;
        xbus_cyc_i = 1'b1;
        @(negedge clk_i);
        xbus_stb_i = 1'b0;
        xbus_cyc_i = 1'b0;
        #1;
        check("cyc_low_resp", {30'h0, xbus_err_o, xbus_ack_o}, 32'h0);
        check("cyc_low_push", acc_tx_data_o, 32'h77);
        @(negedge clk_i);

        // RX fill to full, then flush (byte-enable gated)
        acc_rx_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            acc_rx_data_i = 32'h100 + i;
            @(negedge clk_i);
        end
        acc_rx_valid_i = 1'b0;
        check("rx_ready_full", {31'h0, acc_rx_ready_o}, 32'h0);
        acc("status_rx_full", 1'b0, 32'h8, 32'h0, 4'hF, R_ACK, 32'h0010_0108);
        acc("flush_sel_off", 1'b1, 32'hC, 32'h2, 4'h2, R_ACK, 32'h0);
        acc("status_no_flush", 1'b0, 32'h8, 32'h0, 4'hF, R_ACK, 32'h0010_0108);
        acc("flush", 1'b1, 32'hC, 32'h2, 4'hF, R_ACK, 32'h0);
        acc("status_flushed", 1'b0, 32'h8, 32'h0, 4'hF, R_ACK, 32'h0000_0005);
        acc("ctrl_after_flush", 1'b0, 32'hC, 32'h0, 4'hF, R_ACK, 32'h0);

        // reset during the response cycle of a TXDATA write
        xbus_we_i  = 1'b1;
        xbus_adr_i = BASE;
        xbus_dat_i = 32'hCAFE_0001;
        xbus_sel_i = 4'hF;
        xbus_stb_i = 1'b1;
        xbus_cyc_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i      = 1'b1;
        xbus_stb_i = 1'b0;
        @(negedge clk_i);
        check("rst_mid_outs", {27'h0, xbus_ack_o, xbus_err_o, acc_tx_valid_o, acc_rx_ready_o, irq_o}, 32'h0);
        check("rst_mid_dat", xbus_dat_o | acc_tx_data_o, 32'h0);
        xbus_cyc_i = 1'b0;
        xbus_we_i  = 1'b0;
        rst_i      = 1'b0;
        @(negedge clk_i);
        check("rx_ready_after_rst2", {31'h0, acc_rx_ready_o}, 32'h1);
        acc("status_after_rst2", 1'b0, 32'h8, 32'h0, 4'hF, R_ACK, 32'h0000_0005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
